serial_receiver: RTL

- Downstream counterpart of serial_transmitter.
- Accepts the three-wire serial link (transmission frame enable, serial clock, serial data), which is asynchronous to the local clock, and synchronises it into the clk domain.
- Reassembles each frame MSB-first into a parallel word and presents it with a one-cycle valid strobe.
- Sits at the receiving board's link input and feeds application logic (LED display, loopback checker).

---
 rtl/serial_pkg.sv | 18 +
 rtl/sync_ff.sv | 23 ++
 rtl/serial_receiver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link receiver: FSM encoding, default
// synchroniser depth and the bit-counter width helper.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    // Counter must be able to hold the terminal value itself, not just limit-1.
    function automatic int unsigned count_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// Receiver for the three-wire serial link: synchronises the link into clk and
// rebuilds MSB-first frames. Optional odd parity bit: SERIAL_RECEIVER_PARITY_EN.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  transmission,
    input  logic                  serial_clock,
    input  logic                  serial_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  frame_error,
    output logic                  busy
);

`ifdef SERIAL_RECEIVER_PARITY_EN
    localparam int unsigned FRAME_BITS = DATA_WIDTH + 1;
`else
    localparam int unsigned FRAME_BITS = DATA_WIDTH;
`endif
    localparam int unsigned   CW        = count_width(FRAME_BITS);
    localparam logic [CW-1:0] LIMIT     = CW'(FRAME_BITS);
    localparam logic [CW-1:0] DATA_BITS = CW'(DATA_WIDTH);

    logic trans_s, sclk_s, sdata_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_trans (
        .clk (clk),
        .rst (rst),
        .d   (transmission),
        .q   (trans_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (serial_clock),
        .q   (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk (clk),
        .rst (rst),
        .d   (serial_data),
        .q   (sdata_s)
    );

    logic                   sclk_d, trans_d;
    logic [SYNC_STAGES-1:0] prime;
    logic                   armed;
    logic                   sclk_rise, sample;

    // The synchronisers read 0 straight after reset, so a link already mid-frame
    // would look like a fresh rising edge. Arm only after the chains have
    // refilled with real samples and transmission has been seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d  <= 1'b0;
            trans_d <= 1'b0;
            prime   <= '0;
            armed   <= 1'b0;
        end else begin
            sclk_d  <= sclk_s;
            trans_d <= trans_s;
            prime   <= {prime[SYNC_STAGES-2:0], 1'b1};
            if (prime[SYNC_STAGES-1] && !trans_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sample    = sclk_rise & trans_s;

    state_t                state, state_n;
    logic [CW-1:0]         count, count_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n, err_n;
    logic                  extra, extra_n;
`ifdef SERIAL_RECEIVER_PARITY_EN
    logic                  parity, parity_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            shift       <= '0;
            extra       <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
            parity      <= 1'b0;
`endif
        end else begin
            count       <= count_n;
            shift       <= shift_n;
            extra       <= extra_n;
            out_data    <= data_n;
            out_valid   <= valid_n;
            frame_error <= err_n;
`ifdef SERIAL_RECEIVER_PARITY_EN
            parity      <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        shift_n  = shift;
        extra_n  = extra;
        data_n   = out_data;
        valid_n  = 1'b0;
        err_n    = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
        parity_n = parity;
`endif
        case (state)
            IDLE: begin
                if (armed && trans_s && !trans_d) begin
                    state_n  = RECEIVE;
                    count_n  = '0;
                    shift_n  = '0;
                    extra_n  = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
                    parity_n = 1'b0;
`endif
                end
            end
            RECEIVE: begin
                // A full count wins over a simultaneous transmission fall.
                if (count == LIMIT) begin
                    state_n = WAIT_END;
`ifdef SERIAL_RECEIVER_PARITY_EN
                    if (parity) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
`else
                    data_n  = shift;
                    valid_n = 1'b1;
`endif
                end else if (!trans_s) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (sample) begin
                    if (count < DATA_BITS) begin
                        shift_n = {shift[DATA_WIDTH-2:0], sdata_s};
                    end
`ifdef SERIAL_RECEIVER_PARITY_EN
                    parity_n = parity ^ sdata_s;
`endif
                    count_n = count + 1'b1;
                end
            end
            WAIT_END: begin
                if (!trans_s) begin
                    state_n = IDLE;
                end else if (sample && !extra) begin
                    err_n   = 1'b1;
                    extra_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
